// File: rtl/pending_encoder8x3.sv
// Pending-bit encoder: latches an 8-bit request vector and emits set-bit indices lowest-first, one per cycle.
// Latency 1 cycle from accept to first index; out_ready=0 holds everything, req_ready drops while bits remain.
module pending_encoder8x3 (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req,
  output logic       req_ready,
  output logic       out_valid,
  output logic [2:0] out_idx,
  output logic       out_last,
  input  logic       out_ready,
  output logic [3:0] count
);

  logic [7:0] pend;
  logic [7:0] pend_nxt;
  logic       in_fire;
  logic       out_fire;

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    out_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) out_idx = 3'(i);
    end
  end

  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count = count + 4'(pend[i]);
    end
  end

  assign out_valid = (pend != 8'h00);
  assign out_last  = (count == 4'd1);
  assign req_ready = (pend == 8'h00) || (out_last && out_ready);
  assign in_fire   = req_valid && req_ready;
  assign out_fire  = out_valid && out_ready;

  // A new vector overrides the clear of the final bit in the same cycle.
  always_comb begin
    pend_nxt = pend;
    if (in_fire) begin
      pend_nxt = req;
    end else if (out_fire) begin
      pend_nxt = pend & (pend - 8'd1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= 8'h00;
    end else begin
      pend <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_pending_encoder8x3.sv
// Directed bench for pending_encoder8x3: hand-computed vectors covering drain order, back-pressure and reset.
module tb_pending_encoder8x3;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [7:0] req;
  logic       req_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_ready;
  logic [3:0] count;

  int errs;
  int checks;

  pending_encoder8x3 dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req       (req),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a5_idx[4];
    int ff_k;
    a5_idx = '{0, 2, 5, 7};
    errs = 0;
    checks = 0;
    reset = 1'b0;
    req_valid = 1'b0;
    req = 8'h00;
    out_ready = 1'b0;

    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_count", int'(count), 0);
    check("rst_req_ready", int'(req_ready), 1);
    @(negedge clk);
    reset = 1'b1;

    // Single request
    @(negedge clk);
    req_valid = 1'b1; req = 8'h20; out_ready = 1'b1;
    cyc();
    req_valid = 1'b0; #1;
    check("single_valid", int'(out_valid), 1);
    check("single_idx", int'(out_idx), 5);
    check("single_last", int'(out_last), 1);
    check("single_count", int'(count), 1);
    check("single_req_ready", int'(req_ready), 1);
    cyc();
    check("single_after_valid", int'(out_valid), 0);
    check("single_after_count", int'(count), 0);

    // Multi-hot drain 0xA5
    req_valid = 1'b1; req = 8'hA5;
    cyc();
    req_valid = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      check("a5_idx", int'(out_idx), a5_idx[k]);
      check("a5_count", int'(count), 4 - k);
      check("a5_last", int'(out_last), (k == 3) ? 1 : 0);
      cyc();
    end
    check("a5_done_valid", int'(out_valid), 0);

    // Back-pressure, ignored request, then back-to-back vectors
    req_valid = 1'b1; req = 8'h0C; out_ready = 1'b0;
    cyc();
    req = 8'hFF; #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_idx", int'(out_idx), 2);
      check("bp_count", int'(count), 2);
      check("bp_req_ready", int'(req_ready), 0);
      cyc();
    end
    out_ready = 1'b1; req = 8'h81; #1;
    check("b2b_idx2", int'(out_idx), 2);
    check("b2b_rr_idx2", int'(req_ready), 0);
    cyc();
    check("b2b_idx3", int'(out_idx), 3);
    check("b2b_last3", int'(out_last), 1);
    check("b2b_rr_idx3", int'(req_ready), 1);
    cyc();
    req_valid = 1'b0; #1;
    check("b2b_idx0", int'(out_idx), 0);
    check("b2b_count0", int'(count), 2);
    cyc();
    check("b2b_idx7", int'(out_idx), 7);
    check("b2b_last7", int'(out_last), 1);
    cyc();
    check("b2b_done_valid", int'(out_valid), 0);

    // Zero vector then full vector
    req_valid = 1'b1; req = 8'h00;
    cyc();
    check("zero_valid", int'(out_valid), 0);
    check("zero_req_ready", int'(req_ready), 1);
    check("zero_count", int'(count), 0);
    req = 8'hFF;
    cyc();
    req_valid = 1'b0; #1;
    ff_k = 0;
    for (int k = 0; k < 8; k++) begin
      check("ff_idx", int'(out_idx), k);
      check("ff_count", int'(count), 8 - k);
      check("ff_last", int'(out_last), (k == 7) ? 1 : 0);
      ff_k++;
      cyc();
    end
    check("ff_steps", ff_k, 8);
    check("ff_done_valid", int'(out_valid), 0);

    // Asynchronous reset mid-drain
    req_valid = 1'b1; req = 8'hF0;
    cyc();
    req_valid = 1'b0; #1;
    check("ar_first_idx", int'(out_idx), 4);
    check("ar_first_count", int'(count), 4);
    cyc();
    check("ar_second_idx", int'(out_idx), 5);
    check("ar_second_count", int'(count), 3);
    #2;
    reset = 1'b0;
    #1;
    check("ar_count", int'(count), 0);
    check("ar_valid", int'(out_valid), 0);
    check("ar_req_ready", int'(req_ready), 1);
    cyc();
    check("ar_held_valid", int'(out_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b1; req = 8'h02;
    cyc();
    req_valid = 1'b0; #1;
    check("ar_reload_valid", int'(out_valid), 1);
    check("ar_reload_idx", int'(out_idx), 1);
    check("ar_reload_count", int'(count), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pending_encoder8x3.md
PENDING_ENCODER8X3 -- requirements
Module: pending_encoder8x3

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`: input, 1 bit, asynchronous, active-low; 0 clears all state immediately, independent of `clk`.
REQ-003 The block SHALL have the port `req_valid`: input, 1 bit; a request vector is offered on `req`.
REQ-004 The block SHALL have the port `req`: input, 8 bits; one-hot or multi-hot request vector, where bit i is a request for port i.
REQ-005 The block SHALL have the port `req_ready`: output, 1 bit; the block accepts `req` this cycle.
REQ-006 The block SHALL have the port `out_valid`: output, 1 bit; `out_idx` holds a pending index.
REQ-007 The block SHALL have the port `out_idx`: output, 3 bits; the encoded index of the lowest-numbered pending bit.
REQ-008 The block SHALL have the port `out_last`: output, 1 bit; exactly one bit remains pending.
REQ-009 The block SHALL have the port `out_ready`: input, 1 bit; the consumer takes `out_idx` this cycle.
REQ-010 The block SHALL have the port `count`: output, 4 bits; the number of set bits in the pending register (0..8).

Function
REQ-011 The block SHALL hold an 8-bit pending register P; all outputs except `req_ready` SHALL be derived from P only, with no combinational path from `req`/`req_valid` to them.
REQ-012 `out_valid` SHALL equal (P != 0).
REQ-013 `out_idx` SHALL be the index of the lowest set bit of P, with fixed priority (bit 0 highest); when P == 0, `out_idx` SHALL be 3'd0.
REQ-014 `out_last` SHALL be 1 iff exactly one bit of P is set.
REQ-015 `count` SHALL equal the population count of P.
REQ-016 An output handshake SHALL occur when `out_valid` and `out_ready` are both 1; on that clock edge the bit P[`out_idx`] SHALL clear and no other bit SHALL change, except as specified in REQ-018.
REQ-017 `req_ready` SHALL equal (P == 0) OR (`out_last` AND `out_ready`); this combinational path from `out_ready` is intentional and SHALL have no other inputs.
REQ-018 An input handshake SHALL occur when `req_valid` and `req_ready` are both 1; on that edge P SHALL load `req`, overriding any simultaneous output-handshake clear.
REQ-019 Latency SHALL be 1 cycle: a vector accepted at edge N SHALL present its first index from edge N onward, i.e. in cycle N+1.
REQ-020 Throughput SHALL be one index per cycle while `out_ready` = 1, including back-to-back vectors with no idle cycle between the last index of one vector and the first index of the next.
REQ-021 A zero vector (`req` = 8'h00) accepted SHALL leave P = 0 and produce no output; `req_ready` SHALL remain 1.
REQ-022 When `out_ready` = 0, P and all outputs SHALL hold their values.
REQ-023 `req_valid` while `req_ready` = 0 SHALL be ignored; P SHALL be unaffected.
REQ-024 An input vector with all 8 bits set SHALL yield indices 0,1,...,7 in order over 8 handshakes, with `count` decrementing 8..1.

Reset
REQ-025 While `reset` = 0, P SHALL be 0, giving `out_valid`=0, `out_idx`=0, `out_last`=0, `count`=0 and `req_ready`=1.
REQ-026 Reset asserted mid-drain SHALL discard all pending bits at once, with no further `out_valid`.
REQ-027 After `reset` deasserts, the first rising edge SHALL accept input normally.
REQ-028 The block SHALL hold no other state.

Verification
REQ-029 Single request: load `req`=8'h20, `out_ready`=1 -> next cycle `out_valid`=1, `out_idx`=5, `out_last`=1, `count`=1; the following cycle `out_valid`=0.
REQ-030 Multi-hot drain: load 8'hA5, `out_ready`=1 -> `out_idx` sequence 0,2,5,7 on consecutive cycles; `count` 4,3,2,1; `out_last` high only with 7.
REQ-031 Back-pressure and back-to-back: load 8'h0C, hold `out_ready`=0 for 3 cycles -> `out_idx`=2 held and `req_ready`=0; then `out_ready`=1 with `req_valid`=1, `req`=8'h81 -> indices 2,3,0,7 with no gap, and `req_ready`=1 in the cycle index 3 is consumed.
REQ-032 Zero vector and full vector: accept 8'h00 -> `out_valid` stays 0 and `req_ready`=1; accept 8'hFF -> indices 0..7 over 8 cycles, with `count` 8 down to 1.
REQ-033 Async reset: load 8'hF0, consume one index, then assert `reset`=0 between clock edges -> `count`=0 and `out_valid`=0 immediately; after release, load 8'h02 -> `out_idx`=1.
